// File: rtl/rect_waveform_unit.sv
// Rectangle channel output stage: duty sequencer, length counter, envelope and amplitude mux.
// Optional envelope generator enabled by defining RECT_ENVELOPE_EN; otherwise iVolume drives the amplitude.
module rect_waveform_unit (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iTimer_tick,
    input  logic        iSweep_silence,
    input  logic [10:0] iPeriod,
    input  logic        iQuarter_frame,
    input  logic        iHalf_frame,
    input  logic [1:0]  iDuty,
    input  logic        iLength_halt,
    input  logic        iConst_volume,
    input  logic [3:0]  iVolume,
    input  logic        iLength_load,
    input  logic [4:0]  iLength_index,
    input  logic        iEnable,
    output logic [3:0]  oSample,
    output logic        oLength_active
);
    localparam int unsigned STEP_W   = 3;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned VOL_W    = 4;
    localparam int unsigned PERIOD_W = 11;
    localparam int unsigned PAT_W    = 8;

    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(8);
    localparam logic [VOL_W-1:0]    MAX_DECAY  = VOL_W'(15);

    logic [STEP_W-1:0] step;
    logic [LEN_W-1:0]  lengthCount;
    logic [LEN_W-1:0]  lengthTable_c;
    logic [PAT_W-1:0]  dutyPattern_c;
    logic              dutyBit_c;
    logic              muted_c;
    logic [VOL_W-1:0]  amplitude_c;

    // Length table lookup
    always_comb begin
        lengthTable_c = '0;
        case (iLength_index)
            5'd0:  lengthTable_c = LEN_W'(10);
            5'd1:  lengthTable_c = LEN_W'(254);
            5'd2:  lengthTable_c = LEN_W'(20);
            5'd3:  lengthTable_c = LEN_W'(2);
            5'd4:  lengthTable_c = LEN_W'(40);
            5'd5:  lengthTable_c = LEN_W'(4);
            5'd6:  lengthTable_c = LEN_W'(80);
            5'd7:  lengthTable_c = LEN_W'(6);
            5'd8:  lengthTable_c = LEN_W'(160);
            5'd9:  lengthTable_c = LEN_W'(8);
            5'd10: lengthTable_c = LEN_W'(60);
            5'd11: lengthTable_c = LEN_W'(10);
            5'd12: lengthTable_c = LEN_W'(14);
            5'd13: lengthTable_c = LEN_W'(12);
            5'd14: lengthTable_c = LEN_W'(26);
            5'd15: lengthTable_c = LEN_W'(14);
            5'd16: lengthTable_c = LEN_W'(12);
            5'd17: lengthTable_c = LEN_W'(16);
            5'd18: lengthTable_c = LEN_W'(24);
            5'd19: lengthTable_c = LEN_W'(18);
            5'd20: lengthTable_c = LEN_W'(48);
            5'd21: lengthTable_c = LEN_W'(20);
            5'd22: lengthTable_c = LEN_W'(96);
            5'd23: lengthTable_c = LEN_W'(22);
            5'd24: lengthTable_c = LEN_W'(192);
            5'd25: lengthTable_c = LEN_W'(24);
            5'd26: lengthTable_c = LEN_W'(72);
            5'd27: lengthTable_c = LEN_W'(26);
            5'd28: lengthTable_c = LEN_W'(16);
            5'd29: lengthTable_c = LEN_W'(28);
            5'd30: lengthTable_c = LEN_W'(32);
            5'd31: lengthTable_c = LEN_W'(30);
            default: lengthTable_c = '0;
        endcase
    end

    // Duty patterns stored with bit N = sequencer step N
    always_comb begin
        dutyPattern_c = '0;
        case (iDuty)
            2'd0:    dutyPattern_c = 8'b0000_0010;
            2'd1:    dutyPattern_c = 8'b0000_0110;
            2'd2:    dutyPattern_c = 8'b0001_1110;
            2'd3:    dutyPattern_c = 8'b1111_1001;
            default: dutyPattern_c = '0;
        endcase
        dutyBit_c = dutyPattern_c[step];
    end

    // Duty step counter; a length load restarts the waveform
    always_ff @(posedge iClk) begin
        if (iReset) begin
            step <= '0;
        end else if (iLength_load) begin
            step <= '0;
        end else if (iTimer_tick) begin
            step <= step + STEP_W'(1);
        end
    end

    // Length counter; disabling the channel clears it and blocks loads
    always_ff @(posedge iClk) begin
        if (iReset || !iEnable) begin
            lengthCount <= '0;
        end else if (iLength_load) begin
            lengthCount <= lengthTable_c;
        end else if (iHalf_frame && !iLength_halt && (lengthCount != '0)) begin
            lengthCount <= lengthCount - LEN_W'(1);
        end
    end

`ifdef RECT_ENVELOPE_EN
    logic             envStart;
    logic [VOL_W-1:0] envDivider;
    logic [VOL_W-1:0] envDecay;

    // Envelope: quarter frame sees the start flag as it was before a same-cycle load
    always_ff @(posedge iClk) begin
        if (iReset) begin
            envStart   <= 1'b0;
            envDivider <= '0;
            envDecay   <= '0;
        end else begin
            if (iQuarter_frame) begin
                if (envStart) begin
                    envDecay   <= MAX_DECAY;
                    envDivider <= iVolume;
                end else if (envDivider == '0) begin
                    envDivider <= iVolume;
                    if (envDecay != '0) begin
                        envDecay <= envDecay - VOL_W'(1);
                    end else if (iLength_halt) begin
                        envDecay <= MAX_DECAY;
                    end
                end else begin
                    envDivider <= envDivider - VOL_W'(1);
                end
            end
            if (iLength_load) begin
                envStart <= 1'b1;
            end else if (iQuarter_frame) begin
                envStart <= 1'b0;
            end
        end
    end

    always_comb begin
        amplitude_c = iConst_volume ? iVolume : envDecay;
    end
`else
    logic unusedConstVolume_c;

    always_comb begin
        unusedConstVolume_c = iConst_volume;
        amplitude_c         = iVolume;
    end
`endif

    always_comb begin
        muted_c = (lengthCount == '0) || iSweep_silence || (iPeriod < MIN_PERIOD) || !dutyBit_c;
    end

    // Registered outputs
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oSample        <= '0;
            oLength_active <= 1'b0;
        end else begin
            oSample        <= muted_c ? '0 : amplitude_c;
            oLength_active <= (lengthCount != '0);
        end
    end

endmodule

// File: tb/tb_rect_waveform_unit.sv
// Self-checking bench for rect_waveform_unit: directed test-plan steps then random traffic against a behavioural model.
// Honours RECT_ENVELOPE_EN the same way the design does.
module tb_rect_waveform_unit;
    logic        iClk = 1'b0;
    logic        iReset = 1'b1;
    logic        iTimer_tick = 1'b0;
    logic        iSweep_silence = 1'b0;
    logic [10:0] iPeriod = 11'd100;
    logic        iQuarter_frame = 1'b0;
    logic        iHalf_frame = 1'b0;
    logic [1:0]  iDuty = 2'd0;
    logic        iLength_halt = 1'b0;
    logic        iConst_volume = 1'b1;
    logic [3:0]  iVolume = 4'd0;
    logic        iLength_load = 1'b0;
    logic [4:0]  iLength_index = 5'd0;
    logic        iEnable = 1'b0;
    logic [3:0]  oSample;
    logic        oLength_active;

    rect_waveform_unit dut (
        .iClk(iClk), .iReset(iReset), .iTimer_tick(iTimer_tick), .iSweep_silence(iSweep_silence),
        .iPeriod(iPeriod), .iQuarter_frame(iQuarter_frame), .iHalf_frame(iHalf_frame), .iDuty(iDuty),
        .iLength_halt(iLength_halt), .iConst_volume(iConst_volume), .iVolume(iVolume),
        .iLength_load(iLength_load), .iLength_index(iLength_index), .iEnable(iEnable),
        .oSample(oSample), .oLength_active(oLength_active)
    );

    always #5 iClk = ~iClk;

    int nAsserts = 0;
    int nFails = 0;

    int lenTable [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                          12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
    // Written as in the datasheet: leftmost character is step 0
    logic [7:0] dutyPat [4] = '{8'b0100_0000, 8'b0110_0000, 8'b0111_1000, 8'b1001_1111};

    int mStep = 0;
    int mLen = 0;
    int mStart = 0;
    int mDiv = 0;
    int mDecay = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from the pre-edge model, advance the model, then compare
    task automatic stepCycle(input string tag);
        logic [7:0] expSample;
        logic [7:0] expActive;
        int amp;
        bit dutyOn;
        if (iReset) begin
            expSample = 8'd0;
            expActive = 8'd0;
        end else begin
            dutyOn = dutyPat[iDuty][7 - mStep];
`ifdef RECT_ENVELOPE_EN
            amp = iConst_volume ? int'(iVolume) : mDecay;
`else
            amp = int'(iVolume);
`endif
            expSample = (mLen == 0 || iSweep_silence || int'(iPeriod) < 8 || !dutyOn) ? 8'd0 : 8'(amp);
            expActive = (mLen != 0) ? 8'd1 : 8'd0;
        end

        if (iReset) begin
            mStep = 0; mLen = 0; mStart = 0; mDiv = 0; mDecay = 0;
        end else begin
            if (iLength_load) mStep = 0;
            else if (iTimer_tick) mStep = (mStep + 1) % 8;

            if (!iEnable) mLen = 0;
            else if (iLength_load) mLen = lenTable[iLength_index];
            else if (iHalf_frame && !iLength_halt && mLen > 0) mLen = mLen - 1;

            if (iQuarter_frame) begin
                if (mStart != 0) begin
                    mStart = 0; mDecay = 15; mDiv = int'(iVolume);
                end else if (mDiv == 0) begin
                    mDiv = int'(iVolume);
                    if (mDecay > 0) mDecay = mDecay - 1;
                    else if (iLength_halt) mDecay = 15;
                end else begin
                    mDiv = mDiv - 1;
                end
            end
            if (iLength_load) mStart = 1;
        end

        @(posedge iClk);
        #1;
        check({tag, ".sample"}, {4'd0, oSample}, expSample);
        check({tag, ".active"}, {7'd0, oLength_active}, expActive);
    endtask

    task automatic runCycles(input int n, input string tag);
        repeat (n) stepCycle(tag);
    endtask

    task automatic clearStrobes();
        iTimer_tick = 1'b0;
        iQuarter_frame = 1'b0;
        iHalf_frame = 1'b0;
        iLength_load = 1'b0;
    endtask

    initial begin
        logic [3:0] seqD2 [8];
        seqD2 = '{4'd0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};

        // Reset state
        runCycles(3, "reset");
        check("resetSample", {4'd0, oSample}, 8'd0);
        iReset = 1'b0;
        runCycles(1, "postReset");

        // 50% duty waveform with constant volume 9
        iEnable = 1'b1; iConst_volume = 1'b1; iVolume = 4'd9; iDuty = 2'd2; iPeriod = 11'd100;
        iLength_index = 5'd1; iLength_load = 1'b1;
        runCycles(1, "load1");
        clearStrobes();
        iTimer_tick = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                stepCycle("duty2");
                check("duty2Seq", {4'd0, oSample}, {4'd0, seqD2[i]});
            end
        end
        check("duty2Active", {7'd0, oLength_active}, 8'd1);
        clearStrobes();

        // Length 2 expiry and saturation
        iLength_index = 5'd3; iLength_load = 1'b1;
        runCycles(1, "load3");
        clearStrobes();
        iHalf_frame = 1'b1;
        runCycles(2, "halfFrame");
        clearStrobes();
        runCycles(1, "expire");
        check("expireActive", {7'd0, oLength_active}, 8'd0);
        iHalf_frame = 1'b1;
        runCycles(1, "halfFrameAt0");
        clearStrobes();
        runCycles(2, "holdZero");

        // Envelope decay with and without loop
        iDuty = 2'd3; iConst_volume = 1'b0; iVolume = 4'd0; iLength_index = 5'd1;
        for (int h = 0; h < 2; h++) begin
            iLength_halt = 1'(h);
            iLength_load = 1'b1;
            runCycles(1, "envLoad");
            clearStrobes();
            iQuarter_frame = 1'b1;
            runCycles(20, h == 0 ? "envDecay" : "envLoop");
            clearStrobes();
        end
        iLength_halt = 1'b0;
        iConst_volume = 1'b0; iVolume = 4'd2;
        iLength_load = 1'b1; iQuarter_frame = 1'b1;
        runCycles(1, "envLoadQf");
        clearStrobes();
        iQuarter_frame = 1'b1;
        runCycles(12, "envDivider");
        clearStrobes();

        // Mute rules with 75% duty
        iConst_volume = 1'b1; iVolume = 4'd12; iDuty = 2'd3;
        iLength_load = 1'b1;
        runCycles(1, "muteLoad");
        clearStrobes();
        iPeriod = 11'd7;
        runCycles(2, "period7");
        check("period7Sample", {4'd0, oSample}, 8'd0);
        iPeriod = 11'd8;
        runCycles(2, "period8");
        check("period8Sample", {4'd0, oSample}, 8'd12);
        iSweep_silence = 1'b1;
        runCycles(1, "silence");
        check("silenceSample", {4'd0, oSample}, 8'd0);
        iSweep_silence = 1'b0;
        runCycles(1, "unsilence");

        // Load + half frame + tick together
        iTimer_tick = 1'b1;
        runCycles(3, "advance");
        iLength_index = 5'd5; iLength_load = 1'b1; iHalf_frame = 1'b1;
        runCycles(1, "simul");
        clearStrobes();
        runCycles(2, "simulAfter");

        // Enable gating
        iEnable = 1'b0; iLength_load = 1'b1;
        runCycles(2, "disabledLoad");
        clearStrobes();
        iEnable = 1'b1; iLength_load = 1'b1;
        runCycles(1, "enLoad");
        clearStrobes();
        runCycles(1, "enPlay");
        iEnable = 1'b0;
        runCycles(2, "midDisable");
        check("midDisableActive", {7'd0, oLength_active}, 8'd0);
        iEnable = 1'b1;

        // Reset overriding strobes, then the first strobe after reset
        iLength_load = 1'b1;
        runCycles(1, "preReset");
        iReset = 1'b1; iTimer_tick = 1'b1; iHalf_frame = 1'b1; iQuarter_frame = 1'b1;
        runCycles(2, "resetStrobes");
        iReset = 1'b0;
        runCycles(3, "postResetStrobes");
        clearStrobes();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            iReset         = ($urandom_range(0, 149) == 0);
            iTimer_tick    = 1'($urandom_range(0, 1));
            iQuarter_frame = ($urandom_range(0, 3) == 0);
            iHalf_frame    = ($urandom_range(0, 3) == 0);
            iLength_load   = ($urandom_range(0, 15) == 0);
            iLength_index  = 5'($urandom_range(0, 31));
            iEnable        = ($urandom_range(0, 31) != 0);
            iLength_halt   = ($urandom_range(0, 2) == 0);
            iConst_volume  = 1'($urandom_range(0, 1));
            iVolume        = 4'($urandom_range(0, 15));
            iDuty          = 2'($urandom_range(0, 3));
            iSweep_silence = ($urandom_range(0, 7) == 0);
            iPeriod        = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 15))
                                                         : 11'($urandom_range(0, 2047));
            stepCycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
